mem_access_unit: RTL and testbench

//  Initiator side of the byte-addressable data RAM interface (Addr/Data/W_EN/sel/Output_Data).

---
 rtl/mem_if_pkg.sv | 55 +++++
 rtl/load_extend.sv | 23 ++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the data RAM initiator: op, sel and error encodings, segment bounds.
package mem_if_pkg;

   typedef enum logic [2:0] {
      OpLw  = 3'b000,
      OpLh  = 3'b001,
      OpLhu = 3'b010,
      OpLb  = 3'b011,
      OpLbu = 3'b100,
      OpSw  = 3'b101,
      OpSh  = 3'b110,
      OpSb  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      WW = 2'b00,
      WH = 2'b01,
      WB = 2'b10
   } sel_e;

   typedef enum logic [1:0] {
      ErrNone     = 2'b00,
      ErrMisalign = 2'b01,
      ErrIseg     = 2'b10
   } err_e;

   localparam logic [31:0] ISEG_START_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] ISEG_END_DEFAULT   = 32'h0045_0000;

   function automatic logic op_is_store(input op_e op);
      return (op == OpSw) || (op == OpSh) || (op == OpSb);
   endfunction

   function automatic sel_e op_sel(input op_e op);
      sel_e sel;
      case (op)
         OpLw, OpSw:        sel = WW;
         OpLh, OpLhu, OpSh: sel = WH;
         default:           sel = WB;
      endcase
      return sel;
   endfunction

   // Byte accesses can never be misaligned.
   function automatic logic op_misaligned(input op_e op, input logic [1:0] addr_lo);
      logic mis;
      case (op_sel(op))
         WW:      mis = (addr_lo != 2'b00);
         WH:      mis = addr_lo[0];
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational sign/zero extension of the RAM read word according to the load op.
module load_extend
   import mem_if_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  op_e                   op,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] result
);

   always_comb begin
      result = rdata;
      case (op)
         OpLh:    result = {{(DATA_WIDTH-16){rdata[15]}}, rdata[15:0]};
         OpLhu:   result = {{(DATA_WIDTH-16){1'b0}}, rdata[15:0]};
         OpLb:    result = {{(DATA_WIDTH-8){rdata[7]}}, rdata[7:0]};
         OpLbu:   result = {{(DATA_WIDTH-8){1'b0}}, rdata[7:0]};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for the byte-addressable data RAM.
// Rejects misaligned accesses and stores into the instruction segment without touching the RAM.
module mem_access_unit
   import mem_if_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] ISEG_START = ADDRESS_WIDTH'(ISEG_START_DEFAULT),
   parameter logic [ADDRESS_WIDTH-1:0] ISEG_END   = ADDRESS_WIDTH'(ISEG_END_DEFAULT)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     Req_Valid,
   output logic                     Req_Ready,
   input  logic [2:0]               Req_Op,
   input  logic [ADDRESS_WIDTH-1:0] Req_Addr,
   input  logic [DATA_WIDTH-1:0]    Req_WData,
   output logic [ADDRESS_WIDTH-1:0] Mem_Addr,
   output logic [DATA_WIDTH-1:0]    Mem_Data,
   output logic                     Mem_W_EN,
   output logic [1:0]               Mem_Sel,
   input  logic [DATA_WIDTH-1:0]    Mem_RData,
   output logic                     Resp_Valid,
   input  logic                     Resp_Ready,
   output logic [DATA_WIDTH-1:0]    Resp_Data,
   output logic [1:0]               Resp_Err
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]               state_q, state_d;
   op_e                      op_q, op_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]    mem_data_q, mem_data_d;
   sel_e                     mem_sel_q, mem_sel_d;
   logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;
   err_e                     resp_err_q, resp_err_d;

   op_e                      req_op;
   err_e                     req_err;
   logic                     req_in_iseg;
   logic [DATA_WIDTH-1:0]    load_data;

   assign req_op      = op_e'(Req_Op);
   assign req_in_iseg = (Req_Addr >= ISEG_START) && (Req_Addr <= ISEG_END);

   // Misalignment takes precedence over the segment check.
   always_comb begin
      req_err = ErrNone;
      if (op_misaligned(req_op, Req_Addr[1:0])) begin
         req_err = ErrMisalign;
      end else if (op_is_store(req_op) && req_in_iseg) begin
         req_err = ErrIseg;
      end
   end

   load_extend #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_extend (
      .op     (op_q),
      .rdata  (Mem_RData),
      .result (load_data)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      mem_sel_d   = mem_sel_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      case (state_q)
         IDLE: begin
            if (Req_Valid) begin
               op_d       = req_op;
               resp_err_d = req_err;
               if (req_err != ErrNone) begin
                  resp_data_d = '0;
                  state_d     = RESP;
               end else begin
                  // RAM-facing registers only move for accesses that will reach the RAM.
                  mem_addr_d = Req_Addr;
                  mem_data_d = Req_WData;
                  mem_sel_d  = op_sel(req_op);
                  state_d    = ACCESS;
               end
            end
         end
         ACCESS: begin
            resp_data_d = op_is_store(op_q) ? '0 : load_data;
            state_d     = RESP;
         end
         RESP: begin
            if (Resp_Ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         op_q        <= OpLw;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_sel_q   <= WW;
         resp_data_q <= '0;
         resp_err_q  <= ErrNone;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         mem_sel_q   <= mem_sel_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   // Write enable is decoded from state so an asynchronous reset drops it immediately.
   assign Mem_W_EN   = (state_q == ACCESS) && op_is_store(op_q);
   assign Req_Ready  = (state_q == IDLE);
   assign Resp_Valid = (state_q == RESP);
   assign Mem_Addr   = mem_addr_q;
   assign Mem_Data   = mem_data_q;
   assign Mem_Sel    = mem_sel_q;
   assign Resp_Data  = resp_data_q;
   assign Resp_Err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte RAM model indexed by address bits [5:0].
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        Req_Valid = 1'b0;
   logic        Req_Ready;
   logic [2:0]  Req_Op = 3'b000;
   logic [31:0] Req_Addr = 32'h0;
   logic [31:0] Req_WData = 32'h0;
   logic [31:0] Mem_Addr;
   logic [31:0] Mem_Data;
   logic        Mem_W_EN;
   logic [1:0]  Mem_Sel;
   logic [31:0] Mem_RData = 32'h0;
   logic        Resp_Valid;
   logic        Resp_Ready = 1'b0;
   logic [31:0] Resp_Data;
   logic [1:0]  Resp_Err;

   localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011;
   localparam logic [2:0] LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

   int n_vec = 0;
   int n_miss = 0;
   int wen_count = 0;
   logic [1:0] last_sel = 2'b11;
   logic [7:0] ram [0:63] = '{default: 8'h00};
   logic [5:0] widx;

   mem_access_unit dut (
      .CLK        (CLK),
      .RST        (RST),
      .Req_Valid  (Req_Valid),
      .Req_Ready  (Req_Ready),
      .Req_Op     (Req_Op),
      .Req_Addr   (Req_Addr),
      .Req_WData  (Req_WData),
      .Mem_Addr   (Mem_Addr),
      .Mem_Data   (Mem_Data),
      .Mem_W_EN   (Mem_W_EN),
      .Mem_Sel    (Mem_Sel),
      .Mem_RData  (Mem_RData),
      .Resp_Valid (Resp_Valid),
      .Resp_Ready (Resp_Ready),
      .Resp_Data  (Resp_Data),
      .Resp_Err   (Resp_Err)
   );

   always #5 CLK = ~CLK;

   assign widx = Mem_Addr[5:0];

   function automatic logic [31:0] rd_word(input logic [5:0] a);
      return {ram[a + 6'd3], ram[a + 6'd2], ram[a + 6'd1], ram[a]};
   endfunction

   // Read data settles mid-cycle, ahead of the edge that captures it.
   always @(negedge CLK) Mem_RData <= rd_word(widx);

   always @(posedge CLK) begin
      if (Mem_W_EN) begin
         wen_count <= wen_count + 1;
         last_sel  <= Mem_Sel;
         ram[widx] <= Mem_Data[7:0];
         if (Mem_Sel != 2'b10) ram[widx + 6'd1] <= Mem_Data[15:8];
         if (Mem_Sel == 2'b00) begin
            ram[widx + 6'd2] <= Mem_Data[23:16];
            ram[widx + 6'd3] <= Mem_Data[31:24];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] data, output logic [1:0] err, output int lat);
      @(negedge CLK);
      Req_Valid = 1'b1;
      Req_Op    = op;
      Req_Addr  = addr;
      Req_WData = wdata;
      lat  = 0;
      data = 32'h0;
      err  = 2'b00;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK);
         lat++;
         @(negedge CLK);
         Req_Valid = 1'b0;
         if (Resp_Valid) break;
      end
      if (!Resp_Valid) begin
         check("resp_timeout", {31'b0, Resp_Valid}, 32'h1);
         return;
      end
      data = Resp_Data;
      err  = Resp_Err;
      Resp_Ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      Resp_Ready = 1'b0;
   endtask

   task automatic xfer(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic [1:0] exp_err, input int exp_lat, input int exp_wen);
      logic [31:0] d;
      logic [1:0]  e;
      int          lat;
      int          w0;
      w0 = wen_count;
      run_req(op, addr, wdata, d, e, lat);
      check({tag, ".data"}, d, exp_data);
      check({tag, ".err"}, {30'b0, e}, {30'b0, exp_err});
      check({tag, ".lat"}, lat, exp_lat);
      check({tag, ".wen"}, wen_count - w0, exp_wen);
   endtask

   initial begin
      int w0;
      #12;
      check("rst.req_ready", {31'b0, Req_Ready}, 32'h1);
      check("rst.w_en", {31'b0, Mem_W_EN}, 32'h0);
      check("rst.mem_addr", Mem_Addr, 32'h0);
      check("rst.mem_data", Mem_Data, 32'h0);
      check("rst.mem_sel", {30'b0, Mem_Sel}, 32'h0);
      check("rst.resp_valid", {31'b0, Resp_Valid}, 32'h0);
      check("rst.resp_data", Resp_Data, 32'h0);
      check("rst.resp_err", {30'b0, Resp_Err}, 32'h0);
      @(negedge CLK);
      RST = 1'b1;

      // Word store/load and extension of sub-word loads
      xfer("sw0", SW, 32'h1000_0000, 32'hDEAD_BEEF, 32'h0, 2'b00, 2, 1);
      check("sw0.sel", {30'b0, last_sel}, 32'h0);
      xfer("lw0", LW, 32'h1000_0000, 32'h0, 32'hDEAD_BEEF, 2'b00, 2, 0);
      xfer("lhu0", LHU, 32'h1000_0000, 32'h0, 32'h0000_BEEF, 2'b00, 2, 0);
      xfer("lh2", LH, 32'h1000_0002, 32'h0, 32'hFFFF_DEAD, 2'b00, 2, 0);
      xfer("lb3", LB, 32'h1000_0003, 32'h0, 32'hFFFF_FFDE, 2'b00, 2, 0);
      xfer("sw4", SW, 32'h1000_0004, 32'h0000_0080, 32'h0, 2'b00, 2, 1);
      xfer("lb4", LB, 32'h1000_0004, 32'h0, 32'hFFFF_FF80, 2'b00, 2, 0);
      xfer("lbu4", LBU, 32'h1000_0004, 32'h0, 32'h0000_0080, 2'b00, 2, 0);
      xfer("lh4", LH, 32'h1000_0004, 32'h0, 32'h0000_0080, 2'b00, 2, 0);
      xfer("sb1", SB, 32'h1000_0001, 32'hAAAA_AA55, 32'h0, 2'b00, 2, 1);
      check("sb1.sel", {30'b0, last_sel}, 32'h2);
      xfer("lw0b", LW, 32'h1000_0000, 32'h0, 32'hDEAD_55EF, 2'b00, 2, 0);
      xfer("sh6", SH, 32'h1000_0006, 32'h1234_C3A5, 32'h0, 2'b00, 2, 1);
      check("sh6.sel", {30'b0, last_sel}, 32'h1);
      xfer("lw4", LW, 32'h1000_0004, 32'h0, 32'hC3A5_0080, 2'b00, 2, 0);

      // Misaligned accesses
      xfer("lw_mis", LW, 32'h1000_0002, 32'h0, 32'h0, 2'b01, 1, 0);
      xfer("sh_mis", SH, 32'h1000_0001, 32'h0000_1111, 32'h0, 2'b01, 1, 0);
      xfer("lh_mis", LH, 32'h1000_0003, 32'h0, 32'h0, 2'b01, 1, 0);
      xfer("lw0c", LW, 32'h1000_0000, 32'h0, 32'hDEAD_55EF, 2'b00, 2, 0);

      // Instruction segment protection and its boundaries
      xfer("sw_iseg", SW, 32'h0040_0010, 32'hFFFF_FFFF, 32'h0, 2'b10, 1, 0);
      xfer("lw_iseg", LW, 32'h0040_0010, 32'h0, 32'h0, 2'b00, 2, 0);
      xfer("sb_iseg_lo", SB, 32'h0040_0000, 32'h11, 32'h0, 2'b10, 1, 0);
      xfer("sb_iseg_hi", SB, 32'h0045_0000, 32'h22, 32'h0, 2'b10, 1, 0);
      xfer("sb_below", SB, 32'h003F_FFFF, 32'h33, 32'h0, 2'b00, 2, 1);
      xfer("sb_above", SB, 32'h0045_0021, 32'h77, 32'h0, 2'b00, 2, 1);
      xfer("lbu_above", LBU, 32'h0045_0021, 32'h0, 32'h0000_0077, 2'b00, 2, 0);
      xfer("sw_iseg_mis", SW, 32'h0040_0012, 32'h0, 32'h0, 2'b01, 1, 0);

      // Response held under backpressure; a new request must be ignored
      @(negedge CLK);
      Req_Valid = 1'b1;
      Req_Op    = LW;
      Req_Addr  = 32'h1000_0004;
      @(posedge CLK);
      @(negedge CLK);
      Req_Valid = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check("hold.valid0", {31'b0, Resp_Valid}, 32'h1);
      Req_Valid = 1'b1;
      Req_Op    = SW;
      Req_Addr  = 32'h1000_0000;
      Req_WData = 32'h0;
      w0 = wen_count;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         check("hold.valid", {31'b0, Resp_Valid}, 32'h1);
         check("hold.data", Resp_Data, 32'hC3A5_0080);
         check("hold.err", {30'b0, Resp_Err}, 32'h0);
         check("hold.req_ready", {31'b0, Req_Ready}, 32'h0);
      end
      Req_Valid  = 1'b0;
      Resp_Ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      Resp_Ready = 1'b0;
      check("hold.idle", {31'b0, Req_Ready}, 32'h1);
      check("hold.wen", wen_count - w0, 32'h0);
      xfer("lw0d", LW, 32'h1000_0000, 32'h0, 32'hDEAD_55EF, 2'b00, 2, 0);

      // Reset in the middle of a store access
      @(negedge CLK);
      Req_Valid = 1'b1;
      Req_Op    = SW;
      Req_Addr  = 32'h1000_0008;
      Req_WData = 32'h1234_5678;
      w0 = wen_count;
      @(posedge CLK);
      @(negedge CLK);
      Req_Valid = 1'b0;
      check("rstmid.wen_before", {31'b0, Mem_W_EN}, 32'h1);
      check("rstmid.addr_before", Mem_Addr, 32'h1000_0008);
      #1 RST = 1'b0;
      #1;
      check("rstmid.wen_after", {31'b0, Mem_W_EN}, 32'h0);
      check("rstmid.req_ready", {31'b0, Req_Ready}, 32'h1);
      check("rstmid.resp_valid", {31'b0, Resp_Valid}, 32'h0);
      check("rstmid.mem_addr", Mem_Addr, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      check("rstmid.wen_count", wen_count - w0, 32'h0);
      xfer("lw8", LW, 32'h1000_0008, 32'h0, 32'h0, 2'b00, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
